// File: rtl/expr_buffer.sv
// Editable token buffer with cursor; edge-detects keypad control levels and
// streams the stored expression to the evaluator over valid/ready on eval.
module expr_buffer #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 32,
    localparam int unsigned cw = $clog2(depth + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [width-1:0] dataIn,
    input  logic             insert,
    input  logic             del_pulse,
    input  logic             ptrLeft_pulse,
    input  logic             ptrRight_pulse,
    input  logic             eval_pulse,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [cw-1:0]    count,
    output logic [cw-1:0]    cursor,
    output logic             full,
    output logic             empty,
    output logic             busy
);

    typedef enum logic {EDIT, STREAM} state_t;

    state_t           state, state_nxt;
    logic [width-1:0] entries     [depth];
    logic [width-1:0] entries_nxt [depth];
    logic [cw-1:0]    count_nxt, cursor_nxt, rd, rd_nxt, rd_inc;
    logic [cw-1:0]    count_m1, cursor_m1;
    logic [width-1:0] out_data_nxt, next_tok;
    logic             out_valid_nxt, out_last_nxt, busy_nxt;
    logic             insert_q, del_q, left_q, right_q, eval_q;
    logic             ins_rise, del_rise, left_rise, right_rise, eval_rise;

    assign ins_rise   = insert & ~insert_q;
    assign del_rise   = del_pulse & ~del_q;
    assign left_rise  = ptrLeft_pulse & ~left_q;
    assign right_rise = ptrRight_pulse & ~right_q;
    assign eval_rise  = eval_pulse & ~eval_q;

    assign full      = (count == cw'(depth));
    assign empty     = (count == '0);
    assign count_m1  = count - cw'(1);
    assign cursor_m1 = cursor - cw'(1);
    assign rd_inc    = rd + cw'(1);

    // Token that follows the one currently presented
    always_comb begin
        next_tok = '0;
        for (int i = 0; i < int'(depth); i++) begin
            if (cw'(i) == rd_inc) next_tok = entries[i];
        end
    end

    always_comb begin
        state_nxt     = state;
        entries_nxt   = entries;
        count_nxt     = count;
        cursor_nxt    = cursor;
        rd_nxt        = rd;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        busy_nxt      = busy;
        case (state)
            EDIT: begin
                if (eval_rise) begin
                    if (count != '0) begin
                        state_nxt     = STREAM;
                        rd_nxt        = '0;
                        out_data_nxt  = entries[0];
                        out_valid_nxt = 1'b1;
                        out_last_nxt  = (count == cw'(1));
                        busy_nxt      = 1'b1;
                    end
                end else if (del_rise) begin
                    if (cursor != '0) begin
                        for (int i = 0; i < int'(depth) - 1; i++) begin
                            if (cw'(i) >= cursor_m1 && cw'(i) < count_m1)
                                entries_nxt[i] = entries[i+1];
                        end
                        for (int i = 0; i < int'(depth); i++) begin
                            if (cw'(i) == count_m1) entries_nxt[i] = '0;
                        end
                        count_nxt  = count_m1;
                        cursor_nxt = cursor_m1;
                    end
                end else if (ins_rise) begin
                    if (!full) begin
                        for (int i = 1; i < int'(depth); i++) begin
                            if (cw'(i) > cursor && cw'(i) <= count)
                                entries_nxt[i] = entries[i-1];
                        end
                        for (int i = 0; i < int'(depth); i++) begin
                            if (cw'(i) == cursor) entries_nxt[i] = dataIn;
                        end
                        count_nxt  = count + cw'(1);
                        cursor_nxt = cursor + cw'(1);
                    end
                end else if (left_rise) begin
                    if (cursor != '0) cursor_nxt = cursor_m1;
                end else if (right_rise) begin
                    if (cursor < count) cursor_nxt = cursor + cw'(1);
                end
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_nxt     = EDIT;
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        busy_nxt      = 1'b0;
                    end else begin
                        rd_nxt       = rd_inc;
                        out_data_nxt = next_tok;
                        out_last_nxt = (rd_inc == count_m1);
                    end
                end
            end
            default: state_nxt = EDIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= EDIT;
            count     <= '0;
            cursor    <= '0;
            rd        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            insert_q  <= 1'b0;
            del_q     <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            eval_q    <= 1'b0;
            for (int i = 0; i < int'(depth); i++) entries[i] <= '0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            cursor    <= cursor_nxt;
            rd        <= rd_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            busy      <= busy_nxt;
            entries   <= entries_nxt;
            // Edge history tracks in every state so held levels never refire
            insert_q  <= insert;
            del_q     <= del_pulse;
            left_q    <= ptrLeft_pulse;
            right_q   <= ptrRight_pulse;
            eval_q    <= eval_pulse;
        end
    end

endmodule

// File: tb/tb_expr_buffer.sv
// Scoreboard bench for expr_buffer: queue-based reference model of the token
// list, randomized edit/eval traffic, monitor comparing the streamed tokens.
module tb_expr_buffer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dataIn = '0;
    logic       insert = 1'b0, del_pulse = 1'b0, ptrLeft_pulse = 1'b0;
    logic       ptrRight_pulse = 1'b0, eval_pulse = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_last, full, empty, busy;
    logic [5:0] count, cursor;

    expr_buffer dut (
        .clock(clock), .reset(reset), .dataIn(dataIn), .insert(insert),
        .del_pulse(del_pulse), .ptrLeft_pulse(ptrLeft_pulse),
        .ptrRight_pulse(ptrRight_pulse), .eval_pulse(eval_pulse),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .count(count), .cursor(cursor),
        .full(full), .empty(empty), .busy(busy)
    );

    always #5 clock = ~clock;

    int         total = 0;
    int         bad = 0;
    int         xfers = 0;
    logic [8:0] exp_q[$];
    logic [7:0] model[$];
    int         mcur = 0;
    bit         ready_pat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"},  32'(count),  32'(model.size()));
        check({tag, "_cursor"}, 32'(cursor), 32'(mcur));
        check({tag, "_full"},   32'(full),   32'(model.size() == 32));
        check({tag, "_empty"},  32'(empty),  32'(model.size() == 0));
    endtask

    // Reference behaviour: list edit with priority eval > del > insert > left > right
    task automatic model_apply(input bit ev, input bit dl, input bit in, input bit pl,
                               input bit pr, input logic [7:0] d, output bit st);
        st = 1'b0;
        if (ev) begin
            if (model.size() > 0) begin
                st = 1'b1;
                foreach (model[i]) exp_q.push_back({i == model.size() - 1, model[i]});
            end
        end else if (dl) begin
            if (mcur > 0) begin model.delete(mcur - 1); mcur--; end
        end else if (in) begin
            if (model.size() < 32) begin model.insert(mcur, d); mcur++; end
        end else if (pl) begin
            if (mcur > 0) mcur--;
        end else if (pr) begin
            if (mcur < model.size()) mcur++;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, "_pending_tokens"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    // Called at posedge+1; raises the selected levels for hold cycles, then low cycles
    task automatic press(input bit ev, input bit dl, input bit in, input bit pl, input bit pr,
                         input logic [7:0] d, input int hold, input int low);
        bit st;
        model_apply(ev, dl, in, pl, pr, d, st);
        dataIn = d; eval_pulse = ev; del_pulse = dl; insert = in;
        ptrLeft_pulse = pl; ptrRight_pulse = pr;
        repeat (hold) @(posedge clock);
        #1;
        eval_pulse = 0; del_pulse = 0; insert = 0; ptrLeft_pulse = 0; ptrRight_pulse = 0;
        repeat (low) @(posedge clock);
        #1;
        if (st) wait_done("stream");
    endtask

    always @(posedge clock) begin
        #2;
        if (ready_pat.size() > 0) out_ready = ready_pat.pop_front();
        else out_ready = 1'($urandom_range(0, 1));
    end

    logic       stall = 1'b0;
    logic [7:0] st_d;
    logic       st_l;
    logic [8:0] e;

    // Monitor: compare every accepted token against the scoreboard queue
    always @(negedge clock) begin
        if (!reset) begin
            stall = 1'b0;
        end else begin
            if (stall) check("hold_while_stalled", {22'd0, out_valid, out_last, out_data},
                             {22'd0, 1'b1, st_l, st_d});
            stall = 1'b0;
            if (out_valid && out_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_token: got 0x%0h, expected no token", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("token", {23'd0, out_last, out_data}, {23'd0, e});
                end
            end else if (out_valid) begin
                stall = 1'b1; st_d = out_data; st_l = out_last;
            end
        end
    end

    initial begin
        bit st;
        int start, n;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_last",  32'(out_last), 0);
        check("rst_data",  32'(out_data), 0);
        check_state("rst");
        repeat (3) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1;

        press(0, 0, 1, 0, 0, 8'h01, 3, 2);
        press(0, 0, 1, 0, 0, 8'h2A, 3, 2);
        press(0, 0, 1, 0, 0, 8'h02, 3, 2);
        check_state("three_inserts");
        repeat (2) press(0, 0, 0, 1, 0, 8'h00, 1, 1);
        press(0, 0, 1, 0, 0, 8'h1E, 2, 1);
        check_state("mid_insert");
        press(0, 1, 0, 0, 0, 8'h00, 2, 1);
        check_state("mid_delete");
        repeat (5) press(0, 0, 0, 0, 1, 8'h00, 1, 1);
        check_state("right_saturate");

        // Directed readout with a fixed ready pattern and an insert rise mid-stream
        ready_pat = '{0, 0, 1, 0, 1, 1};
        model_apply(1, 0, 0, 0, 0, 8'h00, st);
        eval_pulse = 1;
        @(posedge clock); #1;
        check("stream_start_busy",  32'(busy), 1);
        check("stream_start_valid", 32'(out_valid), 1);
        eval_pulse = 0; insert = 1; dataIn = 8'h55;
        @(posedge clock); #1;
        check("stream_mid_busy", 32'(busy), 1);
        insert = 0;
        wait_done("directed");
        check_state("after_stream");
        model_apply(1, 0, 0, 0, 0, 8'h00, st);
        eval_pulse = 1;
        @(posedge clock); #1;
        check("back_to_back_busy", 32'(busy), 1);
        eval_pulse = 0;
        wait_done("back_to_back");

        press(0, 1, 1, 0, 0, 8'h77, 1, 1);
        check_state("ins_del_same_cycle");
        while (model.size() > 0) press(0, 1, 0, 0, 0, 8'h00, 1, 1);
        check_state("drained");
        press(1, 0, 0, 0, 0, 8'h00, 2, 1);
        for (int i = 0; i < 4; i++) begin
            check("empty_eval_valid", 32'(out_valid), 0);
            check("empty_eval_busy", 32'(busy), 0);
            @(posedge clock); #1;
        end

        for (int i = 0; i < 32; i++) press(0, 0, 1, 0, 0, 8'(i), 1, 1);
        check_state("filled");
        press(0, 0, 1, 0, 0, 8'h99, 1, 1);
        check_state("insert_when_full");
        repeat (32) press(0, 0, 0, 1, 0, 8'h00, 1, 1);
        press(0, 1, 0, 0, 0, 8'h00, 1, 1);
        check_state("delete_at_zero");
        press(1, 0, 0, 0, 0, 8'h00, 1, 1);
        check_state("after_full_stream");

        // Randomized edits, coincident rises and occasional readouts
        for (int k = 0; k < 160; k++) begin
            int op = $urandom_range(0, 9);
            logic [7:0] d = 8'($urandom);
            int h = $urandom_range(1, 3);
            int l = $urandom_range(1, 2);
            case (op)
                0, 1, 2, 3: press(0, 0, 1, 0, 0, d, h, l);
                4, 5:       press(0, 1, 0, 0, 0, d, h, l);
                6:          press(0, 0, 0, 1, 0, d, h, l);
                7:          press(0, 0, 0, 0, 1, d, h, l);
                8:          press(1'($urandom), 1'($urandom), 1'($urandom),
                                  1'($urandom), 1'($urandom), d, h, l);
                default:    press(1, 0, 0, 0, 0, d, h, l);
            endcase
            check_state("random");
        end

        // Asynchronous reset in the middle of a readout
        repeat (3) press(0, 0, 1, 0, 0, 8'($urandom), 1, 1);
        ready_pat = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        model_apply(1, 0, 0, 0, 0, 8'h00, st);
        start = xfers;
        eval_pulse = 1;
        n = 0;
        while (xfers == start && n < 50) begin @(posedge clock); #1; n++; end
        check("reset_test_first_xfer", 32'(xfers - start), 1);
        #1 reset = 0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_busy",  32'(busy), 0);
        exp_q.delete(); model.delete(); mcur = 0;
        check_state("async_rst");
        repeat (2) @(posedge clock);
        #1 reset = 1;
        repeat (4) begin
            @(posedge clock); #1;
            check("held_eval_valid", 32'(out_valid), 0);
            check("held_eval_busy",  32'(busy), 0);
        end
        model_apply(0, 0, 1, 0, 0, 8'h3C, st);
        insert = 1; dataIn = 8'h3C;
        @(posedge clock); #1;
        insert = 0;
        @(posedge clock); #1;
        check_state("insert_eval_held");
        check("held_eval_no_refire", 32'(busy), 0);
        eval_pulse = 0;
        @(posedge clock); #1;
        press(1, 0, 0, 0, 0, 8'h00, 1, 1);
        check_state("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
